ga_fitness_dispatcher: RTL and testbench

Parametrised multi-channel fitness dispatcher between the GA core and N independent fitness evaluators. It accepts individuals tagged with their population address and issues each to an idle evaluator using the existing start/finish/individual/error handshake. It returns each tagged error to the core and tracks the best (lowest-error) individual seen since the last clear. It replaces the single-evaluator fitness interface and lets evaluations overlap.

---
 rtl/ga_fitness_dispatcher.sv | 197 +++++++++++++++++++
 tb/tb_ga_fitness_dispatcher.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_fitness_dispatcher.sv
// Multi-channel fitness dispatcher: hands tagged individuals to idle evaluators,
// returns tagged errors round-robin and keeps the lowest-error individual seen.

module ga_fitness_channel #(
    parameter int ErrorWidth             = 32,
    parameter int IndividualWidth        = 32,
    parameter int PopulationAddressWidth = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              claim_i,
    input  logic [IndividualWidth-1:0]        ind_i,
    input  logic [PopulationAddressWidth-1:0] addr_i,
    input  logic                              finish_i,
    input  logic [ErrorWidth-1:0]             error_i,
    input  logic                              grant_i,
    output logic                              start_o,
    output logic                              idle_o,
    output logic                              done_o,
    output logic [IndividualWidth-1:0]        ind_o,
    output logic [PopulationAddressWidth-1:0] addr_o,
    output logic [ErrorWidth-1:0]             err_o
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} st_e;

    st_e                              st_q;
    logic [IndividualWidth-1:0]        ind_q;
    logic [PopulationAddressWidth-1:0] addr_q;
    logic [ErrorWidth-1:0]             err_q;

    // Channel lifecycle; the individual is zeroed whenever the channel is idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q   <= IDLE;
            ind_q  <= '0;
            addr_q <= '0;
            err_q  <= '0;
        end else begin
            case (st_q)
                IDLE: if (claim_i) begin
                    st_q   <= START;
                    ind_q  <= ind_i;
                    addr_q <= addr_i;
                end
                START: st_q <= WAIT;
                WAIT: if (finish_i) begin
                    st_q  <= DONE;
                    err_q <= error_i;
                end
                DONE: if (grant_i) begin
                    st_q  <= IDLE;
                    ind_q <= '0;
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    assign start_o = (st_q == START);
    assign idle_o  = (st_q == IDLE);
    assign done_o  = (st_q == DONE);
    assign ind_o   = ind_q;
    assign addr_o  = addr_q;
    assign err_o   = err_q;
endmodule

module ga_fitness_dispatcher #(
    parameter int ErrorWidth             = 32,
    parameter int IndividualWidth        = 32,
    parameter int PopulationAddressWidth = 5,
    parameter int Channels               = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                reqValid,
    output logic                                reqReady,
    input  logic [IndividualWidth-1:0]          reqIndividual,
    input  logic [PopulationAddressWidth-1:0]   reqAddress,
    output logic [Channels-1:0]                 fitnessStart,
    output logic [Channels*IndividualWidth-1:0] fitnessIndividual,
    input  logic [Channels-1:0]                 fitnessFinish,
    input  logic [Channels*ErrorWidth-1:0]      fitnessError,
    output logic                                resValid,
    output logic [PopulationAddressWidth-1:0]   resAddress,
    output logic [ErrorWidth-1:0]               resError,
    input  logic                                bestClear,
    output logic                                bestValid,
    output logic [ErrorWidth-1:0]               bestError,
    output logic [IndividualWidth-1:0]          bestIndividual,
    output logic [PopulationAddressWidth-1:0]   bestAddress,
    output logic                                busy
);
    localparam int PtrW = (Channels > 1) ? $clog2(Channels) : 1;

    logic [Channels-1:0]                             idle, done, claim, grant;
    logic [Channels-1:0][PopulationAddressWidth-1:0] ch_addr;
    logic [Channels-1:0][ErrorWidth-1:0]             ch_err;
    logic [Channels-1:0][IndividualWidth-1:0]        ch_ind;

    logic [PtrW-1:0] ptr_q, ptr_d, win_idx;
    logic [PtrW:0]   idx;
    logic            win_any, cand_v, claimed;

    logic                              resValid_q, bestValid_q;
    logic [PopulationAddressWidth-1:0] resAddress_q, bestAddress_q;
    logic [ErrorWidth-1:0]             resError_q, bestError_q;
    logic [IndividualWidth-1:0]        bestIndividual_q;

    for (genvar c = 0; c < Channels; c++) begin : g_ch
        ga_fitness_channel #(
            .ErrorWidth(ErrorWidth), .IndividualWidth(IndividualWidth),
            .PopulationAddressWidth(PopulationAddressWidth)
        ) u_ch (
            .clk(clk), .rst(rst), .claim_i(claim[c]), .ind_i(reqIndividual),
            .addr_i(reqAddress), .finish_i(fitnessFinish[c]),
            .error_i(fitnessError[c*ErrorWidth +: ErrorWidth]), .grant_i(grant[c]),
            .start_o(fitnessStart[c]), .idle_o(idle[c]), .done_o(done[c]),
            .ind_o(ch_ind[c]), .addr_o(ch_addr[c]), .err_o(ch_err[c])
        );
        assign fitnessIndividual[c*IndividualWidth +: IndividualWidth] = ch_ind[c];
    end

    assign reqReady = rst & (|idle);
    assign busy     = ~(&idle);

    // Accepted request goes to the lowest-index idle channel.
    always_comb begin
        claim   = '0;
        claimed = 1'b0;
        for (int i = 0; i < Channels; i++) begin
            if (!claimed && idle[i]) begin
                claim[i] = reqValid & rst;
                claimed  = 1'b1;
            end
        end
    end

    // Round-robin pick among DONE channels starting at the pointer.
    always_comb begin
        grant   = '0;
        win_any = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < Channels; k++) begin
            idx = {1'b0, ptr_q} + (PtrW+1)'(k);
            if (idx >= (PtrW+1)'(Channels)) idx = idx - (PtrW+1)'(Channels);
            if (!win_any && done[idx[PtrW-1:0]]) begin
                win_any = 1'b1;
                win_idx = idx[PtrW-1:0];
            end
        end
        if (win_any) grant[win_idx] = 1'b1;
        ptr_d  = (32'(win_idx) == Channels - 1) ? '0 : win_idx + 1'b1;
        cand_v = bestClear ? 1'b0 : bestValid_q;
    end

    // Result register, arbiter pointer and best record; a clear acts before a same-edge result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q            <= '0;
            resValid_q       <= 1'b0;
            resAddress_q     <= '0;
            resError_q       <= '0;
            bestValid_q      <= 1'b0;
            bestError_q      <= '0;
            bestIndividual_q <= '0;
            bestAddress_q    <= '0;
        end else begin
            resValid_q <= win_any;
            if (win_any) begin
                ptr_q        <= ptr_d;
                resAddress_q <= ch_addr[win_idx];
                resError_q   <= ch_err[win_idx];
            end
            if (bestClear) begin
                bestValid_q      <= 1'b0;
                bestError_q      <= '0;
                bestIndividual_q <= '0;
                bestAddress_q    <= '0;
            end
            if (win_any && (!cand_v || ch_err[win_idx] < bestError_q)) begin
                bestValid_q      <= 1'b1;
                bestError_q      <= ch_err[win_idx];
                bestIndividual_q <= ch_ind[win_idx];
                bestAddress_q    <= ch_addr[win_idx];
            end
        end
    end

    assign resValid       = resValid_q;
    assign resAddress     = resAddress_q;
    assign resError       = resError_q;
    assign bestValid      = bestValid_q;
    assign bestError      = bestError_q;
    assign bestIndividual = bestIndividual_q;
    assign bestAddress    = bestAddress_q;
endmodule

// File: tb/tb_ga_fitness_dispatcher.sv
// Bench for ga_fitness_dispatcher: directed scenarios plus a randomized run
// against a behavioural evaluator/scoreboard model.

module tb_ga_fitness_dispatcher;
    localparam int C = 4, EW = 32, IW = 32, AW = 5;

    logic              clk = 1'b0;
    logic              rst, reqValid, reqReady, resValid, bestClear, bestValid, busy;
    logic [IW-1:0]     reqIndividual, bestIndividual;
    logic [AW-1:0]     reqAddress, resAddress, bestAddress;
    logic [C-1:0]      fitnessStart, fitnessFinish;
    logic [C*IW-1:0]   fitnessIndividual;
    logic [C*EW-1:0]   fitnessError;
    logic [EW-1:0]     resError, bestError;

    ga_fitness_dispatcher #(.ErrorWidth(EW), .IndividualWidth(IW),
                            .PopulationAddressWidth(AW), .Channels(C)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
        .reqIndividual(reqIndividual), .reqAddress(reqAddress),
        .fitnessStart(fitnessStart), .fitnessIndividual(fitnessIndividual),
        .fitnessFinish(fitnessFinish), .fitnessError(fitnessError),
        .resValid(resValid), .resAddress(resAddress), .resError(resError),
        .bestClear(bestClear), .bestValid(bestValid), .bestError(bestError),
        .bestIndividual(bestIndividual), .bestAddress(bestAddress), .busy(busy));

    always #5 clk = ~clk;

    int vec = 0, mis = 0;
    logic [AW-1:0] last_a, ra;
    logic [IW-1:0] last_i;
    logic [EW-1:0] re;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; a request seen ready before the edge is dropped after it.
    task automatic step();
        logic acc;
        #1;
        acc = reqValid && reqReady;
        if (acc) begin last_a = reqAddress; last_i = reqIndividual; end
        @(negedge clk);
        if (acc) reqValid = 1'b0;
    endtask

    task automatic fin(input logic [C-1:0] m, input logic [C-1:0][EW-1:0] e);
        fitnessFinish = m;
        fitnessError  = e;
        step();
        fitnessFinish = '0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] ind);
        reqAddress = a; reqIndividual = ind; reqValid = 1'b1;
        for (int k = 0; k < 40 && reqValid; k++) step();
        if (reqValid) begin chk("send_timeout", 0, 1); reqValid = 1'b0; end
    endtask

    task automatic wait_res(output logic [AW-1:0] a, output logic [EW-1:0] e);
        a = '0; e = '0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (resValid) begin a = resAddress; e = resError; return; end
        end
        chk("res_timeout", 0, 1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) step();
        rst = 1'b1;
    endtask

    function automatic logic [EW-1:0] herr(logic [IW-1:0] ind);
        return ind[31] ? ind : {29'b0, ind[2:0]};
    endfunction

    // Random-phase model state
    bit            inflight [C];
    int            cnt [C];
    logic [AW-1:0] chaddr [C];
    logic [EW-1:0] exp_err [32];
    logic [IW-1:0] exp_ind [32];
    bit            pend [32];
    bit            mb_v, clr_pend;
    logic [EW-1:0] mb_e;
    logic [IW-1:0] mb_i;
    logic [AW-1:0] mb_a, next_a;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; reqValid = 1'b1; reqAddress = 5; reqIndividual = 32'h1234;
        fitnessFinish = '1; fitnessError = '1; bestClear = 1'b0;

        // Reset held with activity on the inputs
        repeat (3) begin
            @(negedge clk);
            chk("rst_start", fitnessStart, 0);
            chk("rst_ind", |fitnessIndividual, 0);
            chk("rst_flags", {resValid, bestValid, busy, reqReady}, 0);
            chk("rst_res", {resAddress, resError}, 0);
            chk("rst_best", {bestAddress, bestError}, 0);
            chk("rst_bind", bestIndividual, 0);
        end
        reqValid = 1'b0; fitnessFinish = '0; fitnessError = '0; rst = 1'b1;
        #1 chk("rel_ready", reqReady, 1);

        // Single flow
        send(3, 32'h0000_00FF);
        chk("sf_start", fitnessStart, 4'b0001);
        chk("sf_ind0", fitnessIndividual[31:0], 32'hFF);
        step();
        chk("sf_start_off", fitnessStart, 0);
        repeat (8) step();
        fin(4'b0001, {32'h0, 32'h0, 32'h0, 32'hAAAA_AA55});
        chk("sf_noearly", resValid, 0);
        chk("sf_busy", busy, 1);
        step();
        chk("sf_rv", resValid, 1);
        chk("sf_addr", resAddress, 3);
        chk("sf_err", resError, 32'hAAAA_AA55);
        chk("sf_bv", bestValid, 1);
        chk("sf_ba", bestAddress, 3);
        chk("sf_be", bestError, 32'hAAAA_AA55);
        chk("sf_bi", bestIndividual, 32'hFF);
        step();
        chk("sf_rv_pulse", resValid, 0);
        chk("sf_ind_idle", fitnessIndividual[31:0], 0);
        chk("sf_busy_off", busy, 0);

        do_reset(1);

        // Fill all channels, fifth request is held
        for (int i = 0; i < C; i++) begin
            reqAddress = AW'(i); reqIndividual = 100 + i; reqValid = 1'b1;
            step();
            chk("fill_start", fitnessStart, 64'(1) << i);
            chk("fill_ready", reqReady, i < C - 1);
        end
        chk("fill_ind3", fitnessIndividual[127:96], 103);
        reqAddress = 4; reqIndividual = 104; reqValid = 1'b1;
        repeat (3) begin
            step();
            chk("fill_hold_start", fitnessStart, 0);
            chk("fill_hold_rdy", reqReady, 0);
        end

        // Simultaneous finish, pointer at 0
        fin(4'hF, {32'd10, 32'd20, 32'd30, 32'd40});
        chk("sim_nores", resValid, 0);
        for (int k = 0; k < C; k++) begin
            step();
            chk("sim_rv", resValid, 1);
            chk("sim_addr", resAddress, k);
            chk("sim_err", resError, 40 - 10 * k);
        end
        step();
        chk("sim_rv_end", resValid, 0);
        chk("sim_best_e", bestError, 10);
        chk("sim_best_a", bestAddress, 3);

        // Move the pointer to 2 and rerun
        fin(4'b0001, {32'h0, 32'h0, 32'h0, 32'd50});
        wait_res(ra, re);
        chk("held_addr", ra, 4);
        chk("held_err", re, 50);
        for (int i = 0; i < C; i++) send(AW'(8 + i), 200 + i);
        step();
        fin(4'b0010, {32'h0, 32'h0, 32'd60, 32'h0});
        wait_res(ra, re);
        chk("p2_addr", ra, 9);
        send(12, 212);
        step();
        fin(4'hF, {32'd103, 32'd102, 32'd101, 32'd100});
        begin
            logic [AW-1:0] ord_a [4];
            logic [EW-1:0] ord_e [4];
            ord_a = '{10, 11, 8, 12};
            ord_e = '{102, 103, 100, 101};
            for (int k = 0; k < C; k++) begin
                step();
                chk("rr_rv", resValid, 1);
                chk("rr_addr", resAddress, ord_a[k]);
                chk("rr_err", resError, ord_e[k]);
            end
        end
        chk("rr_best_e", bestError, 10);
        chk("rr_best_a", bestAddress, 3);

        // Tie and clear
        bestClear = 1'b1; step(); bestClear = 1'b0;
        chk("clr_bv", bestValid, 0);
        chk("clr_vals", {bestAddress, bestError}, 0);
        chk("clr_bi", bestIndividual, 0);
        send(1, 300); step(); fin(4'b0001, {32'h0, 32'h0, 32'h0, 32'd5});
        wait_res(ra, re);
        chk("tie1_addr", ra, 1);
        chk("tie1_ba", bestAddress, 1);
        send(2, 301); step(); fin(4'b0001, {32'h0, 32'h0, 32'h0, 32'd5});
        wait_res(ra, re);
        chk("tie2_addr", ra, 2);
        chk("tie2_ba", bestAddress, 1);
        chk("tie2_bi", bestIndividual, 300);
        send(7, 302); step(); fin(4'b0001, {32'h0, 32'h0, 32'h0, 32'd9});
        bestClear = 1'b1; step(); bestClear = 1'b0;
        chk("cc_rv", resValid, 1);
        chk("cc_addr", resAddress, 7);
        chk("cc_bv", bestValid, 1);
        chk("cc_be", bestError, 9);
        chk("cc_ba", bestAddress, 7);
        chk("cc_bi", bestIndividual, 302);

        // Reset in the middle of evaluations
        send(20, 400); send(21, 401); send(22, 402); step();
        chk("mr_busy", busy, 1);
        rst = 1'b0; step();
        chk("mr_busy_rst", busy, 0);
        chk("mr_rdy_rst", reqReady, 0);
        rst = 1'b1;
        fin(4'b0111, {32'h0, 32'd3, 32'd2, 32'd1});
        chk("mr_nores0", resValid, 0);
        repeat (6) begin
            step();
            chk("mr_nores", resValid, 0);
            chk("mr_idle", busy, 0);
        end

        // Randomized run against the scoreboard
        do_reset(2);
        foreach (inflight[c]) begin inflight[c] = 0; cnt[c] = 0; chaddr[c] = '0; end
        foreach (pend[a]) begin pend[a] = 0; exp_err[a] = '0; exp_ind[a] = '0; end
        mb_v = 0; mb_e = '0; mb_i = '0; mb_a = '0; clr_pend = 0; next_a = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int nin;
            step();
            fitnessFinish = '0;
            bestClear = 1'b0;
            if (clr_pend) begin mb_v = 0; mb_e = '0; mb_i = '0; mb_a = '0; clr_pend = 0; end
            if (resValid) begin
                ra = resAddress;
                chk("rnd_pend", pend[ra], 1);
                chk("rnd_err", resError, exp_err[ra]);
                pend[ra] = 0;
                for (int c = 0; c < C; c++)
                    if (inflight[c] && chaddr[c] == ra) inflight[c] = 0;
                if (!mb_v || exp_err[ra] < mb_e) begin
                    mb_v = 1; mb_e = exp_err[ra]; mb_i = exp_ind[ra]; mb_a = ra;
                end
            end
            chk("rnd_bv", bestValid, mb_v);
            chk("rnd_be", bestError, mb_e);
            chk("rnd_bi", bestIndividual, mb_i);
            chk("rnd_ba", bestAddress, mb_a);
            // Evaluators: count down, or throw a stray finish at an idle channel
            for (int c = 0; c < C; c++) begin
                if (inflight[c] && cnt[c] > 0) begin
                    cnt[c]--;
                    if (cnt[c] == 0) begin
                        fitnessFinish[c] = 1'b1;
                        fitnessError[c*EW +: EW] = herr(fitnessIndividual[c*IW +: IW]);
                    end
                end else if (!inflight[c] && $urandom_range(0, 7) == 0) begin
                    fitnessFinish[c] = 1'b1;
                    fitnessError[c*EW +: EW] = $urandom;
                end
            end
            for (int c = 0; c < C; c++) begin
                if (fitnessStart[c]) begin
                    chk("rnd_ind", fitnessIndividual[c*IW +: IW], last_i);
                    inflight[c] = 1; chaddr[c] = last_a;
                    cnt[c] = $urandom_range(1, 6);
                    fitnessFinish[c] = 1'b0;
                end
            end
            nin = 0;
            foreach (inflight[c]) nin += int'(inflight[c]);
            chk("rnd_busy", busy, nin != 0);
            chk("rnd_ready", reqReady, nin < C);
            if ($urandom_range(0, 63) == 0) begin bestClear = 1'b1; clr_pend = 1; end
            if (!reqValid && cyc < 2500 && $urandom_range(0, 2) != 0 && !pend[next_a]) begin
                reqAddress = next_a;
                reqIndividual = $urandom;
                exp_err[next_a] = herr(reqIndividual);
                exp_ind[next_a] = reqIndividual;
                pend[next_a] = 1;
                next_a = next_a + 1'b1;
                reqValid = 1'b1;
            end
        end
        begin
            int np = 0;
            foreach (pend[a]) np += int'(pend[a]);
            chk("rnd_drain", np, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
